// File: rtl/encode42_seq_pkg.sv
// Shared constants and state encoding for the encode42_seq registered 4-to-2 encoder.
`timescale 1ns/100ps

package encode42_seq_pkg;

  localparam int CODE_W = 2;
  localparam int N_REQ  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/encode42_seq_prio_sel4.sv
// prio_sel4: combinational 4-way request selector with a configurable scan start and direction.
`timescale 1ns/100ps

module prio_sel4
  import encode42_seq_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] sel,
  output logic              any,
  output logic              multi
);

  // Round-robin scans upward from start; fixed mode scans downward from start-1,
  // so start=0 yields highest-index-wins.
  always_comb begin
    logic              found;
    logic [CODE_W-1:0] idx;
    // NOTE: every combinationally written variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = RR ? start + CODE_W'(k) : start - CODE_W'(k) - 2'd1;
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any   = |req;
  assign multi = ($countones(req) > 1);

endmodule

// File: rtl/encode42_seq.sv
// encode42_seq: registered 4-to-2 encoder with valid/ready hold. Define ENCODE42_RR_EN for
// round-robin selection instead of fixed highest-index priority.
`timescale 1ns/100ps

module encode42_seq
  import encode42_seq_pkg::*;
#(
  parameter bit          ONEHOT_CHK = 1'b1,
  parameter int unsigned HOLD_MIN   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              multi,
  output logic              busy
);

`ifdef ENCODE42_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_MIN);

  state_e            state, next_state;
  logic [CODE_W-1:0] last;
  logic [3:0]        hold_cnt;
  logic [CODE_W-1:0] start;
  logic [CODE_W-1:0] sel;
  logic              sel_any;
  logic              sel_multi;
  logic              capture;
  logic              accept;

  // After reset last=3, so the first round-robin search begins at bit 0.
  assign start = RR_MODE ? last + 2'd1 : '0;

  prio_sel4 #(.RR(RR_MODE)) u_sel (
    .req   (req),
    .start (start),
    .sel   (sel),
    .any   (sel_any),
    .multi (sel_multi)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: if (en && sel_any) begin
        capture    = 1'b1;
        next_state = ST_HOLD;
      end
      ST_HOLD: if (valid && ready && hold_cnt == 4'd0) begin
        accept     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code     <= '0;
      valid    <= 1'b0;
      multi    <= 1'b0;
      busy     <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else if (capture) begin
      code     <= sel;
      multi    <= ONEHOT_CHK && sel_multi;
      valid    <= 1'b1;
      busy     <= 1'b1;
      last     <= sel;
      hold_cnt <= HOLD_INIT;
    end else if (accept) begin
      valid <= 1'b0;
      busy  <= 1'b0;
    end else if (state == ST_HOLD && hold_cnt != 4'd0) begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_encode42_seq.sv
// Directed self-checking bench for encode42_seq: default, ONEHOT_CHK=0 and HOLD_MIN=3 instances.
`timescale 1ns/100ps

module tb_encode42_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, ready;
  logic [3:0] req;
  logic [1:0] code, code_nc;
  logic       valid, multi, busy;
  logic       valid_nc, multi_nc, busy_nc;

  logic       h_en, h_ready;
  logic [3:0] h_req;
  logic [1:0] h_code;
  logic       h_valid, h_multi, h_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  encode42_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
    .code(code), .valid(valid), .multi(multi), .busy(busy)
  );

  encode42_seq #(.ONEHOT_CHK(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
    .code(code_nc), .valid(valid_nc), .multi(multi_nc), .busy(busy_nc)
  );

  encode42_seq #(.HOLD_MIN(3)) dut_h3 (
    .clk(clk), .rst_n(rst_n), .en(h_en), .req(h_req), .ready(h_ready),
    .code(h_code), .valid(h_valid), .multi(h_multi), .busy(h_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         cnt;
    logic [1:0] rr_exp [5];
`ifdef ENCODE42_RR_EN
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    rr_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    rst_n = 1'b0; en = 1'b0; req = 4'b0000; ready = 1'b0;
    h_en = 1'b0; h_req = 4'b0000; h_ready = 1'b0;

    // Reset values
    #12;
    check("rst_code",  32'(code),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    tick();
    rst_n = 1'b1;

    // T2 single request
    en = 1'b1; req = 4'b0100; ready = 1'b1;
    tick();
    check("t2_code",  32'(code),  32'd2);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_multi", 32'(multi), 32'd0);
    check("t2_busy",  32'(busy),  32'd1);
    en = 1'b0; req = 4'b0000;
    tick();
    check("t2_valid_drop", 32'(valid), 32'd0);
    check("t2_busy_drop",  32'(busy),  32'd0);

    // T3 priority and multi flag
    en = 1'b1; req = 4'b1011; ready = 1'b0;
    tick();
    check("t3_code",     32'(code),     32'd3);
    check("t3_multi",    32'(multi),    32'd1);
    check("t3_code_nc",  32'(code_nc),  32'd3);
    check("t3_multi_nc", 32'(multi_nc), 32'd0);
    check("t3_valid_nc", 32'(valid_nc), 32'd1);
    en = 1'b0; ready = 1'b1;
    tick();
    check("t3_valid_drop", 32'(valid), 32'd0);

    // T4 backpressure: req changes during HOLD are ignored
    en = 1'b1; req = 4'b0010; ready = 1'b0;
    tick();
    check("t4_code", 32'(code), 32'd1);
    req = 4'b1000;
    for (int i = 0; i < 5; i++) tick();
    check("t4_code_held",  32'(code),  32'd1);
    check("t4_valid_held", 32'(valid), 32'd1);
    check("t4_multi_held", 32'(multi), 32'd0);
    ready = 1'b1;
    tick();
    check("t4_accept",   32'(valid), 32'd0);
    check("t4_busy_off", 32'(busy),  32'd0);
    ready = 1'b0;
    tick();
    check("t4_recapture_valid", 32'(valid), 32'd1);
    check("t4_recapture_code",  32'(code),  32'd3);
    en = 1'b0; ready = 1'b1;
    tick();
    check("t4_final_drop", 32'(valid), 32'd0);

    // T5 en gating
    en = 1'b0; req = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t5_gated_valid", 32'(valid), 32'd0);
    check("t5_gated_busy",  32'(busy),  32'd0);

    // T1 asynchronous reset mid-HOLD
    en = 1'b1; req = 4'b1000; ready = 1'b0;
    tick();
    check("t1_pre_code",  32'(code),  32'd3);
    check("t1_pre_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_code",  32'(code),  32'd0);
    check("t1_valid", 32'(valid), 32'd0);
    check("t1_busy",  32'(busy),  32'd0);
    check("t1_multi", 32'(multi), 32'd0);
    en = 1'b0; req = 4'b0000;
    #1;
    rst_n = 1'b1;
    tick();
    check("t1_post_valid", 32'(valid), 32'd0);

    // T5 HOLD_MIN=3 keeps valid high for 4 cycles with ready held
    h_en = 1'b1; h_req = 4'b0001; h_ready = 1'b1;
    tick();
    h_en = 1'b0; h_req = 4'b0000;
    check("h3_code", 32'(h_code), 32'd0);
    check("h3_busy", 32'(h_busy), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (h_valid) cnt++;
      tick();
    end
    check("h3_valid_cycles", 32'(cnt), 32'd4);
    check("h3_multi", 32'(h_multi), 32'd0);

    // T6 successive captures with all requests held
    en = 1'b1; req = 4'b1111; ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("t6_valid_%0d", n), 32'(valid), 32'd1);
      check($sformatf("t6_code_%0d", n),  32'(code),  32'(rr_exp[n]));
      check($sformatf("t6_multi_%0d", n), 32'(multi), 32'd1);
      tick();
      check($sformatf("t6_gap_%0d", n), 32'(valid), 32'd0);
    end
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
